// File: rtl/ascon_ctrl_fsm_gen_pkg.sv
// ascon_ctrl_fsm_gen_pkg: shared round/block defaults and xor-down key/domain encodings for the ASCON control FSM
package ascon_ctrl_fsm_gen_pkg;
    localparam int A_ROUNDS_DEF = 12;
    localparam int B_ROUNDS_DEF = 6;
    localparam int NB_W_DEF     = 4;
    localparam int RND_W        = 4;
    typedef enum logic [1:0] {
        CONF_KEY    = 2'b00,
        CONF_DS     = 2'b01,
        CONF_KEY_DS = 2'b10,
        CONF_FINAL  = 2'b11
    } conf_xor_t;
    function automatic logic [RND_W-1:0] b_first(input int b_rounds);
        return RND_W'(12 - b_rounds);
    endfunction
endpackage

// File: rtl/ascon_ctrl_fsm_gen_round_cnt.sv
// ascon_ctrl_fsm_gen_round_cnt: loadable round counter; p^a rounds start at 0, p^b rounds start at 12-B and both stop on their last round
module ascon_ctrl_fsm_gen_round_cnt
    import ascon_ctrl_fsm_gen_pkg::*;
#(
    parameter int A_ROUNDS = A_ROUNDS_DEF,
    parameter int B_ROUNDS = B_ROUNDS_DEF
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             load,
    input  logic             load_b,
    input  logic             en,
    output logic [RND_W-1:0] cnt,
    output logic             last
);
    logic mode_b;
    assign last = cnt == (mode_b ? RND_W'(11) : RND_W'(A_ROUNDS - 1));
    // holding on the last round keeps round_o steady while the FSM waits for data
    always_ff @(posedge clock_i or negedge resetb_i)
        if (!resetb_i) begin
            cnt    <= '0;
            mode_b <= 1'b0;
        end else if (load) begin
            cnt    <= load_b ? b_first(B_ROUNDS) : '0;
            mode_b <= load_b;
        end else if (en && !last) begin
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/ascon_ctrl_fsm_gen.sv
// ascon_ctrl_fsm_gen: Moore control FSM sequencing init, AD, text and finalisation phases of the ASCON AEAD datapath
module ascon_ctrl_fsm_gen
    import ascon_ctrl_fsm_gen_pkg::*;
#(
    parameter int A_ROUNDS = A_ROUNDS_DEF,
    parameter int B_ROUNDS = B_ROUNDS_DEF,
    parameter int NB_W     = NB_W_DEF
) (
    input  logic            clock_i,
    input  logic            resetb_i,
    input  logic            start_i,
    input  logic            decrypt_i,
    input  logic [NB_W-1:0] nb_ad_i,
    input  logic [NB_W-1:0] nb_txt_i,
    input  logic            data_valid_i,
    output logic [3:0]      round_o,
    output logic            init_state_o,
    output logic            ena_reg_state_o,
    output logic            ena_xor_up_o,
    output logic            ena_xor_down_o,
    output logic [1:0]      conf_xor_down_o,
    output logic            last_blk_o,
    output logic            decrypt_o,
    output logic            ena_cipher_o,
    output logic            cipher_valid_o,
    output logic            ena_tag_o,
    output logic            busy_o,
    output logic            end_o
);
    typedef enum logic [3:0] {
        IDLE, LOAD, INIT, WAIT_AD, ABS_AD, PERM_AD, WAIT_TXT, ABS_TXT,
        PERM_TXT, WAIT_FIN, ABS_FIN, FINAL, TAG, DONE
    } state_t;
    state_t state, next, go_abs, go_wait;
    logic [NB_W-1:0] ad_left, txt_left;
    logic [RND_W-1:0] rnd;
    logic dec_q, last, rnd_load, rnd_load_b, xd;
    // block counters are already decremented by the time a phase's last round decides where to go
    assign go_abs  = (ad_left != '0) ? ABS_AD  : (txt_left > NB_W'(1)) ? ABS_TXT  : ABS_FIN;
    assign go_wait = (ad_left != '0) ? WAIT_AD : (txt_left > NB_W'(1)) ? WAIT_TXT : WAIT_FIN;
    assign rnd_load   = next inside {LOAD, ABS_AD, ABS_TXT, ABS_FIN};
    assign rnd_load_b = next inside {ABS_AD, ABS_TXT};
    ascon_ctrl_fsm_gen_round_cnt #(.A_ROUNDS(A_ROUNDS), .B_ROUNDS(B_ROUNDS)) u_round_cnt (
        .clock_i (clock_i),
        .resetb_i(resetb_i),
        .load    (rnd_load),
        .load_b  (rnd_load_b),
        .en      (ena_reg_state_o),
        .cnt     (rnd),
        .last    (last)
    );
    always_ff @(posedge clock_i or negedge resetb_i)
        if (!resetb_i) begin
            state    <= IDLE;
            ad_left  <= '0;
            txt_left <= '0;
            dec_q    <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && start_i) begin
                dec_q    <= decrypt_i;
                ad_left  <= nb_ad_i;
                txt_left <= (nb_txt_i == '0) ? NB_W'(1) : nb_txt_i;
            end
            if (state == ABS_AD) ad_left <= ad_left - 1'b1;
            if (state inside {ABS_TXT, ABS_FIN}) txt_left <= txt_left - 1'b1;
        end
    always_comb begin
        next = state;
        unique case (state)
            IDLE:                        next = start_i ? LOAD : IDLE;
            LOAD:                        next = INIT;
            INIT, PERM_AD, PERM_TXT:     next = last ? (data_valid_i ? go_abs : go_wait) : state;
            WAIT_AD, WAIT_TXT, WAIT_FIN: next = data_valid_i ? go_abs : state;
            ABS_AD:                      next = PERM_AD;
            ABS_TXT:                     next = PERM_TXT;
            ABS_FIN:                     next = FINAL;
            FINAL:                       next = last ? TAG : FINAL;
            TAG:                         next = DONE;
            DONE:                        next = IDLE;
            default:                     next = IDLE;
        endcase
    end
    always_comb begin
        xd = last && (state inside {INIT, FINAL} || (state == PERM_AD && ad_left == '0));
        round_o         = rnd;
        init_state_o    = state == LOAD;
        ena_reg_state_o = state inside {LOAD, INIT, ABS_AD, PERM_AD, ABS_TXT, PERM_TXT, ABS_FIN, FINAL};
        ena_xor_up_o    = state inside {ABS_AD, ABS_TXT, ABS_FIN};
        ena_xor_down_o  = xd;
        conf_xor_down_o = !xd ? CONF_KEY : (state == FINAL) ? CONF_FINAL : (state == PERM_AD) ? CONF_DS :
                          (ad_left != '0) ? CONF_KEY : CONF_KEY_DS;
        last_blk_o      = state == ABS_FIN;
        decrypt_o       = dec_q;
        ena_cipher_o    = state inside {ABS_TXT, ABS_FIN};
        cipher_valid_o  = state inside {ABS_TXT, ABS_FIN};
        ena_tag_o       = state == TAG;
        busy_o          = state != IDLE;
        end_o           = state == DONE;
    end
endmodule

// File: tb/tb_ascon_ctrl_fsm_gen.sv
// tb_ascon_ctrl_fsm_gen: directed scenarios for the ASCON control FSM; cycle 1 is the cycle start_i is presented
module tb_ascon_ctrl_fsm_gen;
    typedef struct packed {
        logic [3:0] rnd;
        logic init, regst, xu, xd;
        logic [1:0] conf;
        logic lastb, dec, ciph, cv, tag, busy, endo;
    } obs_t;
    localparam int F_CV = 0, F_REG = 1, F_XU = 2, F_XD = 3, F_BUSY = 4, F_DEC = 5, F_LAST = 6;

    logic clock_i = 1'b0, resetb_i = 1'b0, start_i = 1'b0, decrypt_i = 1'b0, data_valid_i = 1'b0;
    logic [3:0] nb_ad_i = '0, nb_txt_i = '0, round_o;
    logic init_state_o, ena_reg_state_o, ena_xor_up_o, ena_xor_down_o, last_blk_o, decrypt_o;
    logic ena_cipher_o, cipher_valid_o, ena_tag_o, busy_o, end_o;
    logic [1:0] conf_xor_down_o;
    obs_t cur;
    obs_t tr [0:255];
    int errors = 0, checks = 0;

    always #5 clock_i = ~clock_i;

    ascon_ctrl_fsm_gen dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .decrypt_i(decrypt_i),
        .nb_ad_i(nb_ad_i), .nb_txt_i(nb_txt_i), .data_valid_i(data_valid_i), .round_o(round_o),
        .init_state_o(init_state_o), .ena_reg_state_o(ena_reg_state_o), .ena_xor_up_o(ena_xor_up_o),
        .ena_xor_down_o(ena_xor_down_o), .conf_xor_down_o(conf_xor_down_o), .last_blk_o(last_blk_o),
        .decrypt_o(decrypt_o), .ena_cipher_o(ena_cipher_o), .cipher_valid_o(cipher_valid_o),
        .ena_tag_o(ena_tag_o), .busy_o(busy_o), .end_o(end_o)
    );

    assign cur = {round_o, init_state_o, ena_reg_state_o, ena_xor_up_o, ena_xor_down_o, conf_xor_down_o,
                  last_blk_o, decrypt_o, ena_cipher_o, cipher_valid_o, ena_tag_o, busy_o, end_o};

    function automatic int cnt_of(input int f);
        int n = 0;
        for (int c = 1; c < 256; c++)
            case (f)
                F_CV:    n += int'(tr[c].cv);
                F_REG:   n += int'(tr[c].regst);
                F_XU:    n += int'(tr[c].xu);
                F_XD:    n += int'(tr[c].xd);
                F_BUSY:  n += int'(tr[c].busy);
                F_DEC:   n += int'(tr[c].dec);
                default: n += int'(tr[c].lastb);
            endcase
        return n;
    endfunction

    // one operation; expects to be entered just after a rising edge, leaves just after the edge following DONE
    task automatic run(input int ad, input int txt, input logic dec, input int lo_from, input int lo_len,
                       input int s1, input int s2, input int rst_at, output int end_c);
        end_c = 0;
        nb_ad_i = 4'(ad);
        nb_txt_i = 4'(txt);
        decrypt_i = dec;
        for (int i = 0; i < 256; i++) tr[i] = '0;
        for (int c = 1; c < 200 && end_c == 0; c++) begin
            start_i = (c == 1 || c == s1 || c == s2);
            data_valid_i = !(c >= lo_from && c < lo_from + lo_len);
            @(negedge clock_i);
            tr[c] = cur;
            if (c == rst_at) begin
                resetb_i = 1'b0;
                #1 tr[0] = cur;
                break;
            end
            if (cur.endo) end_c = c;
            @(posedge clock_i);
            #1;
        end
        start_i = 1'b0;
        data_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        resetb_i = 1'b0;
        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        checks++; if (cur !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", cur); end
        resetb_i = 1'b1;
        @(negedge clock_i);
        checks++; if (cur !== '0) begin errors++; $display("FAIL idle_after_reset: got %h want 0", cur); end
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_encrypt();
        int e;
        run(1, 3, 1'b0, 0, 0, 0, 0, 0, e);
        checks++; if (e !== 45) begin errors++; $display("FAIL t1_end_cycle: got %0d want 45", e); end
        checks++; if ({tr[43].tag, tr[44].tag} !== 2'b01) begin errors++; $display("FAIL t1_tag: got %b want 01", {tr[43].tag, tr[44].tag}); end
        checks++; if ({tr[20].cv, tr[26].cv, tr[32].cv} !== 3'b111 || cnt_of(F_CV) !== 3) begin errors++; $display("FAIL t1_cipher_valid: got %0d pulses want 3 at 20,26,32", cnt_of(F_CV)); end
        checks++; if ({tr[2].init, tr[2].regst, tr[2].rnd} !== 6'b11_0000) begin errors++; $display("FAIL t1_load: got %b want 110000", {tr[2].init, tr[2].regst, tr[2].rnd}); end
        checks++; if ({tr[13].xd, tr[13].conf, tr[13].rnd} !== 7'b1_00_1011) begin errors++; $display("FAIL t1_init_last: got %b want 1001011", {tr[13].xd, tr[13].conf, tr[13].rnd}); end
        checks++; if ({tr[14].xu, tr[14].rnd} !== 5'b1_0110) begin errors++; $display("FAIL t1_abs_ad: got %b want 10110", {tr[14].xu, tr[14].rnd}); end
        checks++; if ({tr[19].xd, tr[19].conf} !== 3'b1_01) begin errors++; $display("FAIL t1_ad_domsep: got %b want 101", {tr[19].xd, tr[19].conf}); end
        checks++; if ({tr[43].xd, tr[43].conf} !== 3'b1_11) begin errors++; $display("FAIL t1_final_key: got %b want 111", {tr[43].xd, tr[43].conf}); end
        checks++; if (cnt_of(F_XD) !== 3) begin errors++; $display("FAIL t1_xd_count: got %0d want 3", cnt_of(F_XD)); end
        checks++; if (tr[32].lastb !== 1'b1 || cnt_of(F_LAST) !== 1) begin errors++; $display("FAIL t1_last_blk: got %0d want 1 at 32", cnt_of(F_LAST)); end
        checks++; if (cnt_of(F_REG) !== 42) begin errors++; $display("FAIL t1_reg_en: got %0d want 42", cnt_of(F_REG)); end
        checks++; if (cnt_of(F_BUSY) !== 44 || tr[1].busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %0d want 44", cnt_of(F_BUSY)); end
    endtask

    task automatic test_no_ad();
        int e;
        run(0, 1, 1'b0, 0, 0, 0, 0, 0, e);
        checks++; if (e !== 27) begin errors++; $display("FAIL t2_end_cycle: got %0d want 27", e); end
        checks++; if ({tr[13].xd, tr[13].conf} !== 3'b1_10) begin errors++; $display("FAIL t2_init_conf: got %b want 110", {tr[13].xd, tr[13].conf}); end
        checks++; if (cnt_of(F_XU) !== 1 || {tr[14].xu, tr[14].lastb, tr[14].rnd} !== 6'b11_0000) begin errors++; $display("FAIL t2_abs_fin: got %0d xor_up want 1 at 14", cnt_of(F_XU)); end
        checks++; if ({tr[25].xd, tr[25].conf, tr[26].tag} !== 4'b1_11_1) begin errors++; $display("FAIL t2_final: got %b want 1111", {tr[25].xd, tr[25].conf, tr[26].tag}); end
    endtask

    task automatic test_stall();
        int e, n = 0;
        run(1, 3, 1'b0, 25, 5, 0, 0, 0, e);
        checks++; if (e !== 50) begin errors++; $display("FAIL t3_end_cycle: got %0d want 50", e); end
        for (int c = 26; c <= 30; c++) if (tr[c] === tr[26] && !tr[c].regst && tr[c].busy) n++;
        checks++; if (n !== 5 || tr[26].rnd !== 4'd11) begin errors++; $display("FAIL t3_wait_hold: got %0d steady cycles want 5", n); end
        checks++; if ({tr[20].cv, tr[31].cv, tr[37].cv} !== 3'b111 || cnt_of(F_CV) !== 3) begin errors++; $display("FAIL t3_cipher_valid: got %0d pulses want 3 at 20,31,37", cnt_of(F_CV)); end
        checks++; if (cnt_of(F_REG) !== 42) begin errors++; $display("FAIL t3_reg_en: got %0d want 42", cnt_of(F_REG)); end
    endtask

    task automatic test_decrypt();
        int e;
        run(1, 3, 1'b1, 21, 4, 0, 0, 0, e);
        checks++; if (e !== 45) begin errors++; $display("FAIL t4_end_cycle: got %0d want 45", e); end
        checks++; if (cnt_of(F_DEC) !== 44 || tr[1].dec !== 1'b0) begin errors++; $display("FAIL t4_decrypt_o: got %0d cycles want 44", cnt_of(F_DEC)); end
        checks++; if ({tr[20].cv, tr[26].cv, tr[32].cv, tr[44].tag} !== 4'b1111) begin errors++; $display("FAIL t4_sequence: got %b want 1111", {tr[20].cv, tr[26].cv, tr[32].cv, tr[44].tag}); end
    endtask

    task automatic test_reset_mid();
        int e, n = 0;
        run(1, 3, 1'b1, 0, 0, 0, 0, 22, e);
        checks++; if ({tr[22].regst, tr[22].rnd} !== 5'b1_1000) begin errors++; $display("FAIL t5_perm_txt: got %b want 11000", {tr[22].regst, tr[22].rnd}); end
        checks++; if (tr[0] !== '0) begin errors++; $display("FAIL t5_async_clear: got %h want 0", tr[0]); end
        repeat (3) begin
            @(negedge clock_i);
            if (cur !== '0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL t5_held_in_reset: got %0d nonzero cycles want 0", n); end
        resetb_i = 1'b1;
        @(posedge clock_i);
        #1;
        run(1, 2, 1'b0, 0, 0, 0, 0, 0, e);
        checks++; if (e !== 39) begin errors++; $display("FAIL t5_restart_end: got %0d want 39", e); end
        checks++; if ({tr[20].cv, tr[26].cv} !== 2'b11 || cnt_of(F_CV) !== 2) begin errors++; $display("FAIL t5_restart_cv: got %0d pulses want 2", cnt_of(F_CV)); end
    endtask

    task automatic test_start_ignored();
        int e, n = 0;
        run(0, 0, 1'b0, 0, 0, 20, 27, 0, e);
        checks++; if (e !== 27) begin errors++; $display("FAIL t6_end_cycle: got %0d want 27", e); end
        checks++; if (cnt_of(F_CV) !== 1 || {tr[13].xd, tr[13].conf} !== 3'b1_10) begin errors++; $display("FAIL t6_txt0_as_1: got %0d pulses want 1", cnt_of(F_CV)); end
        repeat (3) begin
            @(negedge clock_i);
            if (busy_o !== 1'b0) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL t6_no_restart: got %0d busy cycles want 0", n); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_no_ad();
        test_stall();
        test_decrypt();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
